// File: rtl/key_op_fifo_pkg.sv
// key_op_fifo_pkg
//   Constants and types shared by the keyboard decoder, the key-operation FIFO
//   and the game player. Having them in one place keeps the operation codes in
//   agreement across those three blocks.
//   - KEY_OP_W   : width of one keyboard operation code
//   - key_op_e   : keyboard operation codes
//   - in_state_e : input handshake states of key_op_fifo
package key_op_fifo_pkg;

  localparam int KEY_OP_W = 3;

  typedef enum logic [KEY_OP_W-1:0] {
    KOP_NONE    = 3'd0,
    KOP_UP      = 3'd1,
    KOP_DOWN    = 3'd2,
    KOP_LEFT    = 3'd3,
    KOP_RIGHT   = 3'd4,
    KOP_SELECT  = 3'd5,
    KOP_HALF    = 3'd6,
    KOP_RESTART = 3'd7
  } key_op_e;

  typedef enum logic [1:0] {
    IN_IDLE     = 2'd0,
    IN_ACK      = 2'd1,
    IN_WAIT_LOW = 2'd2
  } in_state_e;

endpackage

// File: rtl/key_op_ram.sv
// key_op_ram
//   DEPTH x DATA_WIDTH register array with one write port and one registered
//   read port. The read is write-first: when the address being read is written
//   in the same cycle, the new data appears on rdata after the edge.
//   Ports:
//     clock   - system clock
//     reset_n - synchronous active-low reset (clears only the read register)
//     we      - write enable
//     waddr   - write address
//     wdata   - write data
//     raddr   - read address, sampled at the edge
//     rdata   - registered read data
module key_op_ram
  import key_op_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = KEY_OP_W,
  parameter int DEPTH      = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      we,
  input  logic [$clog2(DEPTH)-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [$clog2(DEPTH)-1:0]  raddr,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Bypass lets a word written into an empty FIFO be presented on the
  // very edge that makes out_ready rise.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (we && (waddr == raddr)) begin
      rdata_q <= wdata;
    end else begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/key_op_fifo.sv
// key_op_fifo
//   Buffers decoded keyboard operations between the PS/2 decoder and the game
//   player so keystrokes arriving while the game logic is busy are kept.
//   Ports:
//     clock, reset_n - system clock, synchronous active-low reset
//     in_ready       - decoder has data, held high until acknowledged
//     in_data        - operation code from the decoder
//     in_read_fin    - one-cycle pulse: in_data was captured
//     out_ready      - FIFO not empty, out_data valid
//     out_data       - oldest buffered operation
//     out_read_fin   - consumer took out_data (ignored while empty)
//     flush          - discard all buffered operations
//     count          - current occupancy
//     full           - count == DEPTH
//     refused_cnt    - saturating count of keystrokes seen while full
module key_op_fifo
  import key_op_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = KEY_OP_W,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_read_fin,
  output logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  input  logic                         out_read_fin,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic [CNT_WIDTH-1:0]         refused_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  in_state_e           state_q;
  logic                in_read_fin_q;
  logic                in_ready_q;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CNT_WIDTH-1:0] refused_q;

  logic push, pop, wr_en;

  assign full      = (count_q == CW'(DEPTH));
  assign out_ready = (count_q != '0);

  // A push during flush is still acknowledged, but nothing is stored.
  always_comb begin
    push     = (state_q == IN_IDLE) && in_ready && !full;
    pop      = out_ready && out_read_fin && !flush;
    wr_en    = push && !flush;
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (wr_en && !pop)      count_d = count_q + CW'(1);
      else if (!wr_en && pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IN_IDLE;
      in_read_fin_q <= 1'b0;
      in_ready_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      refused_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      in_ready_q    <= in_ready;
      in_read_fin_q <= 1'b0;
      case (state_q)
        IN_IDLE: begin
          if (push) begin
            state_q       <= IN_ACK;
            in_read_fin_q <= 1'b1;
          end else if (in_ready && full && !in_ready_q) begin
            // Only a fresh press counts; a held refused key counts once.
            refused_q <= sat_inc(refused_q);
          end
        end
        IN_ACK:      state_q <= IN_WAIT_LOW;
        IN_WAIT_LOW: if (!in_ready) state_q <= IN_IDLE;
        default:     state_q <= IN_IDLE;
      endcase
    end
  end

  key_op_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (wr_en),
    .waddr   (wr_ptr_q),
    .wdata   (in_data),
    .raddr   (rd_ptr_d),
    .rdata   (out_data)
  );

  assign in_read_fin = in_read_fin_q;
  assign count       = count_q;
  assign refused_cnt = refused_q;

endmodule

// File: tb/tb_key_op_fifo.sv
module tb_key_op_fifo;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_n, in_ready, out_read_fin, flush;
  logic [2:0] in_data;
  logic       in_read_fin, out_ready, full;
  logic [2:0] out_data;
  logic [2:0] count;
  logic [7:0] refused_cnt;

  always #5 clock = ~clock;

  key_op_fifo #(.DATA_WIDTH(3), .DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_read_fin  (in_read_fin),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_read_fin (out_read_fin),
    .flush        (flush),
    .count        (count),
    .full         (full),
    .refused_cnt  (refused_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue contents, refused counter, ack pulse and a
  // handshake phase (0 = may accept, 1 = acking, 2 = waiting for ready low).
  int mq[$];
  int m_ref   = 0;
  bit m_fin   = 0;
  int m_phase = 0;
  bit m_prev  = 0;
  int fin_seen = 0;

  task automatic tick();
    bit full_m, acc, dpop;
    if (!reset_n) begin
      mq.delete(); m_ref = 0; m_fin = 0; m_phase = 0; m_prev = 0;
    end else begin
      full_m = (mq.size() == DEPTH);
      acc    = (m_phase == 0) && in_ready && !full_m;
      dpop   = (mq.size() != 0) && out_read_fin && !flush;
      if (m_phase == 0 && in_ready && full_m && !m_prev && m_ref < 255) m_ref++;
      if (flush) mq.delete();
      else begin
        if (dpop) void'(mq.pop_front());
        if (acc) mq.push_back(int'(in_data));
      end
      m_fin = acc;
      case (m_phase)
        0: m_phase = acc ? 1 : 0;
        1: m_phase = 2;
        default: m_phase = in_ready ? 2 : 0;
      endcase
      m_prev = in_ready;
    end
    @(posedge clock); #1;
    if (in_read_fin === 1'b1) fin_seen++;
  endtask

  task automatic push_key(input int d);
    in_ready = 1'b1; in_data = 3'(d);
    tick(); tick();
    in_ready = 1'b0;
    tick();
  endtask

  task automatic pop_key();
    out_read_fin = 1'b1; tick(); out_read_fin = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_ready = 0; in_data = 0; out_read_fin = 0; flush = 0;
    tick(); tick();
    reset_n = 1'b1;
    total++; if ({count, out_ready, full, in_read_fin} !== 6'b0) begin bad++;
      $display("FAIL reset_ctrl got %b want 000000", {count, out_ready, full, in_read_fin}); end
    total++; if (out_data !== 3'd0) begin bad++; $display("FAIL reset_data got %0d want 0", out_data); end
    total++; if (refused_cnt !== 8'd0) begin bad++; $display("FAIL reset_refused got %0d want 0", refused_cnt); end
  endtask

  task automatic test_single_key();
    in_ready = 1'b1; in_data = 3'd2; fin_seen = 0;
    tick();
    total++; if ({in_read_fin, out_ready, out_data, count} !== {1'b1, 1'b1, 3'd2, 3'd1}) begin bad++;
      $display("FAIL single_first got fin=%b rdy=%b data=%0d cnt=%0d want 1 1 2 1", in_read_fin, out_ready, out_data, count); end
    repeat (4) tick();
    total++; if (fin_seen !== 1) begin bad++; $display("FAIL single_pulses got %0d want 1", fin_seen); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count got %0d want 1", count); end
    in_ready = 1'b0; tick();
    pop_key();
    total++; if (out_ready !== 1'b0) begin bad++; $display("FAIL single_drain got %b want 0", out_ready); end
  endtask

  task automatic test_order_full();
    for (int k = 1; k <= 4; k++) push_key(k);
    total++; if ({full, count} !== {1'b1, 3'd4}) begin bad++;
      $display("FAIL full_flag got full=%b cnt=%0d want 1 4", full, count); end
    in_ready = 1'b1; in_data = 3'd5; fin_seen = 0;
    tick(); tick();
    in_ready = 1'b0; tick();
    total++; if (fin_seen !== 0) begin bad++; $display("FAIL refused_ack got %0d want 0", fin_seen); end
    total++; if (refused_cnt !== 8'd1) begin bad++; $display("FAIL refused_cnt got %0d want 1", refused_cnt); end
    for (int k = 1; k <= 4; k++) begin
      total++; if (out_data !== 3'(k)) begin bad++; $display("FAIL order_%0d got %0d want %0d", k, out_data, k); end
      pop_key();
    end
    total++; if (out_ready !== 1'b0) begin bad++; $display("FAIL order_empty got %b want 0", out_ready); end
  endtask

  task automatic test_backpressure();
    for (int k = 1; k <= 4; k++) push_key(k);
    in_ready = 1'b1; in_data = 3'd5;
    tick(); tick();
    out_read_fin = 1'b1; tick(); out_read_fin = 1'b0;
    total++; if ({in_read_fin, count} !== {1'b0, 3'd3}) begin bad++;
      $display("FAIL bp_pop_edge got fin=%b cnt=%0d want 0 3", in_read_fin, count); end
    tick();
    total++; if ({in_read_fin, count} !== {1'b1, 3'd4}) begin bad++;
      $display("FAIL bp_capture got fin=%b cnt=%0d want 1 4", in_read_fin, count); end
    tick(); in_ready = 1'b0; tick();
    total++; if (refused_cnt !== 8'(m_ref)) begin bad++;
      $display("FAIL bp_refused got %0d want %0d", refused_cnt, m_ref); end
    for (int k = 2; k <= 5; k++) begin
      total++; if (out_data !== 3'(k)) begin bad++; $display("FAIL bp_order_%0d got %0d want %0d", k, out_data, k); end
      pop_key();
    end
  endtask

  task automatic test_simultaneous();
    int exp[$];
    int d;
    push_key(6); push_key(7);
    exp.push_back(6); exp.push_back(7);
    for (int i = 0; i < 10; i++) begin
      d = int'($urandom_range(0, 7));
      total++; if (out_data !== 3'(exp[0])) begin bad++;
        $display("FAIL simul_data_%0d got %0d want %0d", i, out_data, exp[0]); end
      void'(exp.pop_front()); exp.push_back(d);
      in_ready = 1'b1; in_data = 3'(d); out_read_fin = 1'b1;
      tick();
      out_read_fin = 1'b0;
      total++; if (count !== 3'd2) begin bad++; $display("FAIL simul_count_%0d got %0d want 2", i, count); end
      tick(); in_ready = 1'b0; tick();
    end
    for (int i = 0; i < 2; i++) begin
      total++; if (out_data !== 3'(exp[i])) begin bad++;
        $display("FAIL simul_tail_%0d got %0d want %0d", i, out_data, exp[i]); end
      pop_key();
    end
  endtask

  task automatic test_flush();
    push_key(1); push_key(2); push_key(3);
    in_ready = 1'b1; in_data = 3'd7; flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if ({count, out_ready, in_read_fin} !== {3'd0, 1'b0, 1'b1}) begin bad++;
      $display("FAIL flush_state got cnt=%0d rdy=%b fin=%b want 0 0 1", count, out_ready, in_read_fin); end
    tick(); in_ready = 1'b0; tick();
    push_key(6);
    total++; if ({count, out_data} !== {3'd1, 3'd6}) begin bad++;
      $display("FAIL flush_after got cnt=%0d data=%0d want 1 6", count, out_data); end
    pop_key();
  endtask

  task automatic test_reset_mid();
    in_ready = 1'b1; in_data = 3'd4;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    total++; if ({count, out_ready, full, in_read_fin, out_data, refused_cnt} !== 17'd0) begin bad++;
      $display("FAIL midreset_outs got cnt=%0d rdy=%b full=%b fin=%b data=%0d ref=%0d want all 0",
               count, out_ready, full, in_read_fin, out_data, refused_cnt); end
    fin_seen = 0;
    repeat (4) tick();
    total++; if (fin_seen !== 1) begin bad++; $display("FAIL midreset_pulses got %0d want 1", fin_seen); end
    total++; if ({count, out_data} !== {3'd1, 3'd4}) begin bad++;
      $display("FAIL midreset_data got cnt=%0d data=%0d want 1 4", count, out_data); end
    in_ready = 1'b0; tick();
    pop_key();
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 4; k++) push_key(k);
    for (int i = 0; i < 300; i++) begin
      in_ready = 1'b1; tick();
      in_ready = 1'b0; tick();
    end
    total++; if (refused_cnt !== 8'd255) begin bad++; $display("FAIL saturate got %0d want 255", refused_cnt); end
    repeat (4) pop_key();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      reset_n      = ($urandom_range(0, 99) != 0);
      in_ready     = ($urandom_range(0, 2) != 0);
      in_data      = 3'($urandom_range(0, 7));
      out_read_fin = ($urandom_range(0, 1) != 0);
      flush        = ($urandom_range(0, 24) == 0);
      tick();
      total++;
      if ({count, out_ready, full, in_read_fin, refused_cnt} !==
          {3'(mq.size()), mq.size() != 0, mq.size() == DEPTH, m_fin, 8'(m_ref)}) begin
        bad++;
        if (errs++ < 10) $display("FAIL rand_ctrl_%0d got cnt=%0d rdy=%b full=%b fin=%b ref=%0d want cnt=%0d fin=%b ref=%0d",
                                  i, count, out_ready, full, in_read_fin, refused_cnt, mq.size(), m_fin, m_ref);
      end
      if (mq.size() != 0) begin
        total++;
        if (out_data !== 3'(mq[0])) begin
          bad++;
          if (errs++ < 10) $display("FAIL rand_data_%0d got %0d want %0d", i, out_data, mq[0]);
        end
      end
    end
    reset_n = 1'b1; in_ready = 1'b0; out_read_fin = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_order_full();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_op_fifo.md
Name: key_op_fifo

Overview:
- Buffers decoded keyboard operations between the PS/2 keyboard decoder and the game logic, so that keystrokes made during a busy logic cycle or a step-timer tick are not lost.
- Input side is the decoder's ready/read_fin level handshake; output side presents the same ready/read_fin style to the game player.
- Supports a flush on turn change or reset of the game, and counts keystrokes refused while full, for the seven-segment debug display.

Parameters:
DATA_WIDTH, 3, width of one keyboard operation code
DEPTH, 4, number of buffered operations (power of two, ≥2)
CNT_WIDTH, 8, width of the refused-keystroke counter

Ports:
clock  in  1  system clock; decoder and game player run on this same clock at integration
reset_n  in  1  synchronous reset, active-low
in_ready  in  1  decoder has valid data; held high until acknowledged
in_data  in  DATA_WIDTH  operation code from the decoder
in_read_fin  out  1  one-cycle pulse: in_data has been captured
out_ready  out  1  FIFO non-empty; out_data valid
out_data  out  DATA_WIDTH  oldest buffered operation
out_read_fin  in  1  game logic consumed out_data (pulse, honoured only when out_ready=1)
flush  in  1  discard all buffered operations
count  out  $clog2(DEPTH+1)  current occupancy
full  out  1  count==DEPTH
refused_cnt  out  CNT_WIDTH  keystrokes seen while full, saturating

Behaviour:
- Reset (reset_n=0 at posedge): pointers=0, count=0, in_read_fin=0, out_ready=0, out_data=0, full=0, refused_cnt=0, input FSM=IDLE. Reset mid-transaction abandons any pending ack; no in_read_fin is issued for it.
- Input FSM, three states:
  - IDLE: if in_ready=1 and full=0 at the edge → write in_data at wr_ptr, wr_ptr+1, count+1, drive in_read_fin=1 next cycle, go to ACK.
  - IDLE while full: if in_ready=1 and full=1 → no write, no ack, stay IDLE (backpressure). refused_cnt increments once per in_ready rising edge seen while full, saturating at all-ones.
  - ACK: in_read_fin=1 for exactly this one cycle → go to WAIT_LOW.
  - WAIT_LOW: in_read_fin=0; stay until in_ready=0, then go to IDLE. A held-high ready is never captured twice.
- Output side:
  - out_ready = (count≠0).
  - out_data = mem[rd_ptr], registered, valid in the same cycle out_ready rises. Latency from in_ready capture to out_ready is 1 cycle.
  - out_read_fin=1 with out_ready=1 → rd_ptr+1, count-1.
  - out_read_fin while empty is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, the push is judged on the pre-edge full flag, so it is refused even if a pop occurs in the same cycle.
- Pointers wrap modulo DEPTH.
- flush=1:
  - Next edge: count=0, rd_ptr=wr_ptr, out_ready=0; a same-cycle pop is ignored.
  - A same-cycle push is still acknowledged by the FSM but its data is discarded.
  - refused_cnt is not cleared by flush.
  - The FSM state is not affected by flush.
- All outputs are registered, except full and out_ready, which are decoded from the count register.

Decomposition:
- Shared package (game package): the keyboard operation codes (up/down/left/right/select/half/…) as a 3-bit enum, and the DATA_WIDTH constant, so the decoder, this FIFO and the game player agree.
- One natural sub-module, key_op_ram: DEPTH×DATA_WIDTH register array with one write port and one registered read port.
- The FSM and pointers stay in key_op_fifo.

Test Plan:
1. Single key: in_ready=1 with in_data=3'd2 held 5 cycles → exactly one in_read_fin pulse 1 cycle after capture; out_ready=1, out_data=2, count=1; no second write.
2. Order and full: push 1, 2, 3, 4 (each ready dropped between) → full=1, count=4. A fifth push of 5 gets no ack and refused_cnt=1. Pop four times → out_data sequence 1, 2, 3, 4, then out_ready=0.
3. Backpressure release: while full with in_ready=1 pending, pop once → the pending 5 is captured and acked on the next IDLE edge; subsequent pops yield 2, 3, 4, 5.
4. Simultaneous push/pop at count=2: count stays 2; output order is preserved across pointer wrap after 10 such cycles.
5. Flush with count=3 plus a same-cycle push → count=0, out_ready=0, push acked but absent; a subsequent push of 6 reads back 6.
6. Reset mid-ACK: reset_n=0 the cycle after capture → no in_read_fin, all outputs 0. After release, in_ready still high (new press) → captured once.
